// File: rtl/ntt_core_gf64_pmr_final_reduc.sv
// ntt_core_gf64_pmr_final_reduc
// Purpose : final canonical reduction of a signed, partially reduced 66-bit value
//           from ntt_core_gf64_pmr_add into [0, MOD_M), MOD_M = 2^64-2^32+1.
// Latency : 2+IN_PIPE cycles from in_avail to out_avail, throughput 1/cycle.
// Backpressure: none; every in_avail yields one out_avail, in order, gaps preserved.
// Ports   : clk, s_rst_n (sync, active-low) | in_z[65:0], in_avail, in_side
//           | out_z[63:0], out_avail, out_side.
// Optional: define NTT_CORE_GF64_PMR_FINAL_REDUC_CHECK_EN to add a simulation-only
//           checker (out_z range and in/out avail count consistency).
module ntt_core_gf64_pmr_final_reduc #(
  parameter int         MOD_NTT_W = 64,
  parameter int         IN_PIPE   = 1,
  parameter int         SIDE_W    = 1,
  parameter logic [1:0] RST_SIDE  = 2'b00
) (
  input  logic                   clk,
  input  logic                   s_rst_n,
  input  logic [MOD_NTT_W+1:0]   in_z,
  input  logic                   in_avail,
  input  logic [SIDE_W-1:0]      in_side,
  output logic [MOD_NTT_W-1:0]   out_z,
  output logic                   out_avail,
  output logic [SIDE_W-1:0]      out_side
);

  // The reduction identities below are specific to the Goldilocks prime.
  if (MOD_NTT_W != 64) begin : g_bad_width
    $fatal(1, "ntt_core_gf64_pmr_final_reduc: only MOD_NTT_W=64 is supported");
  end

  localparam logic [63:0]       MOD_LO       = 64'hFFFF_FFFF_0000_0001;
  localparam logic [65:0]       MOD_66       = {2'b00, MOD_LO};
  localparam logic [SIDE_W-1:0] SIDE_RST_VAL = {SIDE_W{RST_SIDE[1]}};

  // ---------------------------------------------------------------------------
  // Entry stage (optionally registered)
  // ---------------------------------------------------------------------------
  logic [65:0]       s0_z;
  logic              s0_avail;
  logic [SIDE_W-1:0] s0_side;

  if (IN_PIPE != 0) begin : g_in_pipe
    always_ff @(posedge clk) begin
      if (!s_rst_n) s0_avail <= 1'b0;
      else          s0_avail <= in_avail;
    end

    always_ff @(posedge clk) begin
      if (in_avail) s0_z <= in_z;
    end

    always_ff @(posedge clk) begin
      if (!s_rst_n && RST_SIDE[0]) s0_side <= SIDE_RST_VAL;
      else if (in_avail)           s0_side <= in_side;
    end
  end else begin : g_in_comb
    assign s0_z     = in_z;
    assign s0_avail = in_avail;
    assign s0_side  = in_side;
  end

  // ---------------------------------------------------------------------------
  // Stage 1: fold the two top bits using 2^64 = 2^32-1 (mod MOD_M).
  // hi*(2^32-1) is formed as (hi<<32) - hi; everything is evaluated mod 2^66,
  // which gives the correct two's-complement result because the true value
  // lies in [-2^33+2, 2^64+2^32-2].
  // ---------------------------------------------------------------------------
  logic [65:0]       hi_ext;
  logic [65:0]       s1_y_nxt;
  logic [65:0]       s1_y;
  logic              s1_avail;
  logic [SIDE_W-1:0] s1_side;

  always_comb begin
    hi_ext   = {{64{s0_z[65]}}, s0_z[65:64]};
    s1_y_nxt = {2'b00, s0_z[63:0]} + {hi_ext[33:0], 32'b0} - hi_ext;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) s1_avail <= 1'b0;
    else          s1_avail <= s0_avail;
  end

  always_ff @(posedge clk) begin
    if (s0_avail) s1_y <= s1_y_nxt;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n && RST_SIDE[0]) s1_side <= SIDE_RST_VAL;
    else if (s0_avail)           s1_side <= s0_side;
  end

  // ---------------------------------------------------------------------------
  // Stage 2: single correction step. Both corrected results fit in 64 bits,
  // so the add/subtract is done on the low 64 bits only (mod 2^64).
  // ---------------------------------------------------------------------------
  logic        s1_neg;
  logic        s1_ge;
  logic [63:0] s2_nxt;

  always_comb begin
    s1_neg = s1_y[65];
    s1_ge  = !s1_neg && (s1_y >= MOD_66);
    s2_nxt = s1_y[63:0];
    if (s1_neg)     s2_nxt = s1_y[63:0] + MOD_LO;
    else if (s1_ge) s2_nxt = s1_y[63:0] - MOD_LO;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n) out_avail <= 1'b0;
    else          out_avail <= s1_avail;
  end

  always_ff @(posedge clk) begin
    if (s1_avail) out_z <= s2_nxt;
  end

  always_ff @(posedge clk) begin
    if (!s_rst_n && RST_SIDE[0]) out_side <= SIDE_RST_VAL;
    else if (s1_avail)           out_side <= s1_side;
  end

`ifdef NTT_CORE_GF64_PMR_FINAL_REDUC_CHECK_EN
  // ---------------------------------------------------------------------------
  // Simulation-only checker
  // ---------------------------------------------------------------------------
  localparam int LATENCY = 2 + IN_PIPE;

  logic [31:0] chk_in_cnt;
  logic [31:0] chk_out_cnt;
  logic [31:0] chk_in_dly [LATENCY];

  // Counts are of cycles strictly before the current one, so
  // out count(t) must equal in count(t-LATENCY).
  always_ff @(posedge clk) begin
    if (!s_rst_n) begin
      chk_in_cnt  <= '0;
      chk_out_cnt <= '0;
      for (int i = 0; i < LATENCY; i++) chk_in_dly[i] <= '0;
    end else begin
      chk_in_cnt    <= chk_in_cnt + {31'd0, in_avail};
      chk_out_cnt   <= chk_out_cnt + {31'd0, out_avail};
      chk_in_dly[0] <= chk_in_cnt;
      for (int i = 1; i < LATENCY; i++) chk_in_dly[i] <= chk_in_dly[i-1];
    end
  end

  always @(posedge clk) begin
    if (s_rst_n) begin
      if (out_avail && (out_z >= MOD_LO)) begin
        $display("%0t ntt_core_gf64_pmr_final_reduc: out_z out of range: %h", $time, out_z);
        $fatal(1);
      end
      if (chk_out_cnt != chk_in_dly[LATENCY-1]) begin
        $display("%0t ntt_core_gf64_pmr_final_reduc: out count %0d != delayed in count %0d",
                 $time, chk_out_cnt, chk_in_dly[LATENCY-1]);
        $fatal(1);
      end
    end
  end
`else
  // Checker not built: no additional logic.
`endif

endmodule

// File: tb/tb_ntt_core_gf64_pmr_final_reduc.sv
module tb_ntt_core_gf64_pmr_final_reduc;

  localparam int SIDE_W = 4;

  logic              clk;
  logic              s_rst_n;
  logic [65:0]       in_z;
  logic              in_avail;
  logic [SIDE_W-1:0] in_side;
  logic [63:0]       out_z;
  logic              out_avail;
  logic [SIDE_W-1:0] out_side;

  ntt_core_gf64_pmr_final_reduc #(
    .MOD_NTT_W (64),
    .IN_PIPE   (1),
    .SIDE_W    (SIDE_W),
    .RST_SIDE  (2'b11)
  ) dut (
    .clk       (clk),
    .s_rst_n   (s_rst_n),
    .in_z      (in_z),
    .in_avail  (in_avail),
    .in_side   (in_side),
    .out_z     (out_z),
    .out_avail (out_avail),
    .out_side  (out_side)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [65:0] z;
    logic [63:0] exp;
  } vec_t;

  typedef struct {
    logic [63:0]       z;
    logic [SIDE_W-1:0] side;
  } sb_t;

  vec_t vecs [10];
  sb_t  sb [$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: signed remainder of the 66-bit value.
  function automatic logic [63:0] ref_mod(input logic [65:0] z);
    logic signed [127:0] v, m, r;
    v = {{62{z[65]}}, z};
    m = 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0001;
    r = v % m;
    if (r < 0) r = r + m;
    return r[63:0];
  endfunction

  task automatic drive(input logic [65:0] z, input logic av, input logic [63:0] exp);
    sb_t e;
    @(negedge clk);
    s_rst_n  = 1'b1;
    in_z     = z;
    in_avail = av;
    in_side  = z[SIDE_W-1:0];
    if (av) begin
      e.z    = exp;
      e.side = z[SIDE_W-1:0];
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    drive(66'd0, 1'b0, 64'd0);
  endtask

  // Monitor: out_avail must equal in_avail three edges earlier; each valid
  // output is compared against the oldest scoreboard entry.
  initial begin
    logic [2:0] av_hist;
    sb_t        e;
    av_hist = '0;
    forever begin
      @(posedge clk);
      if (!s_rst_n) av_hist = '0;
      else          av_hist = {av_hist[1:0], in_avail};
      #1;
      chk("avail_dly", {63'd0, out_avail}, {63'd0, av_hist[2]});
      if (out_avail === 1'b1) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          chk("out_z", out_z, e.z);
          chk("out_side", {60'd0, out_side}, {60'd0, e.side});
        end
      end
    end
  end

  initial begin
    logic [65:0] rz;
    vecs[0] = '{66'h0_0000000000000000, 64'h0000000000000000};
    vecs[1] = '{66'h0_FFFFFFFF00000001, 64'h0000000000000000};
    vecs[2] = '{66'h0_FFFFFFFF00000000, 64'hFFFFFFFF00000000};
    vecs[3] = '{66'h3_FFFFFFFFFFFFFFFF, 64'hFFFFFFFF00000000};
    vecs[4] = '{66'h1_0000000000000000, 64'h00000000FFFFFFFF};
    vecs[5] = '{66'h2_0000000000000000, 64'hFFFFFFFD00000003};
    vecs[6] = '{66'h1_FFFFFFFFFFFFFFFF, 64'h00000001FFFFFFFD};
    vecs[7] = '{66'h0_FFFFFFFFFFFFFFFF, 64'h00000000FFFFFFFE};
    vecs[8] = '{66'h3_00000000FFFFFFFF, 64'h0000000000000000};
    vecs[9] = '{66'h0_0000000012345678, 64'h0000000012345678};

    s_rst_n  = 1'b0;
    in_z     = '0;
    in_avail = 1'b0;
    in_side  = '0;
    repeat (4) @(negedge clk);
    chk("rst_avail", {63'd0, out_avail}, 64'd0);
    chk("rst_side", {60'd0, out_side}, 64'hF);

    // Latency of a single isolated item.
    drive(66'd0, 1'b1, 64'd0);
    idle(); chk("lat_c1", {63'd0, out_avail}, 64'd0);
    idle(); chk("lat_c2", {63'd0, out_avail}, 64'd0);
    idle(); chk("lat_c3", {63'd0, out_avail}, 64'd1);
    chk("lat_z", out_z, 64'd0);

    // Table, back-to-back.
    for (int i = 0; i < 10; i++) drive(vecs[i].z, 1'b1, vecs[i].exp);
    // Table, with gaps.
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i].z, 1'b1, vecs[i].exp);
      idle();
    end
    repeat (4) idle();

    // Reset with three items in flight (s1, s0, and one at the input).
    drive(vecs[3].z, 1'b1, vecs[3].exp);
    drive(vecs[5].z, 1'b1, vecs[5].exp);
    @(negedge clk);
    s_rst_n  = 1'b0;
    in_z     = vecs[6].z;
    in_avail = 1'b1;
    in_side  = 4'h5;
    sb.delete();
    @(negedge clk);
    s_rst_n  = 1'b1;
    in_avail = 1'b0;
    chk("midrst_avail", {63'd0, out_avail}, 64'd0);
    chk("midrst_side", {60'd0, out_side}, 64'hF);
    idle(); chk("midrst_avail2", {63'd0, out_avail}, 64'd0);
    idle(); chk("midrst_avail3", {63'd0, out_avail}, 64'd0);

    // Stream resumes cleanly.
    for (int i = 0; i < 10; i++) drive(vecs[i].z, 1'b1, vecs[i].exp);

    // Random stream, 50% avail.
    for (int i = 0; i < 2000; i++) begin
      rz = {$urandom, $urandom, $urandom};
      drive(rz, $urandom_range(0, 1) == 1, ref_mod(rz));
    end

    // Drain with a bounded wait.
    idle();
    repeat (20) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
